// File: rtl/mul_operand_sequencer.sv
// Operand-pair FIFO and A-then-B serialiser feeding a repeated-addition multiplier.
// Optional WAIT_DONE watchdog: define MUL_SEQ_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | waiting for a queued pair (no result outstanding)
// LOAD_A    | multiplicand on mul_data, mul_start high
// LOAD_B    | multiplier (repeat count) on mul_data
// WAIT_DONE | waiting for mul_done, or watchdog expiry
// HOLD_RES  | product held on res_data until res_ready
module mul_operand_sequencer #(
  parameter int WIDTH          = 16,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] mul_data,
  output logic             mul_start,
  input  logic             mul_done,
  input  logic [WIDTH-1:0] mul_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy,
  output logic             err
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, WAIT_DONE, HOLD_RES} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop, full, empty;
  logic [WIDTH-1:0] op_a, op_b;
  logic             timeout;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && !empty;
  assign busy     = (state != IDLE) || !empty;

  // Storage needs no reset: only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a     <= '0;
      op_b     <= '0;
      res_data <= '0;
    end else begin
      if (pop) begin
        op_a <= mem_a[rd_ptr];
        op_b <= mem_b[rd_ptr];
      end
      // A real done wins over a watchdog expiry on the same edge.
      if (state == WAIT_DONE) begin
        if (mul_done)     res_data <= mul_y;
        else if (timeout) res_data <= '1;
      end
    end
  end

`ifdef MUL_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;
  logic          err_q;

  // Down-counter loaded while entering WAIT_DONE; terminal count ends the wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == LOAD_B)
        tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
      else if (state == WAIT_DONE && tmo_cnt != '0)
        tmo_cnt <= tmo_cnt - TW'(1);
      if (timeout) err_q <= 1'b1;
    end
  end

  assign timeout = (state == WAIT_DONE) && !mul_done && (tmo_cnt == '0);
  assign err     = err_q;
`else
  assign timeout = 1'b0;
  // TIMEOUT_CYCLES only matters when the watchdog is built in.
  assign err     = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!empty) state_nxt = LOAD_A;
      LOAD_A:    state_nxt = LOAD_B;
      LOAD_B:    state_nxt = WAIT_DONE;
      WAIT_DONE: if (mul_done || timeout) state_nxt = HOLD_RES;
      HOLD_RES:  if (res_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mul_data  = '0;
    mul_start = 1'b0;
    res_valid = 1'b0;
    case (state)
      LOAD_A: begin
        mul_data  = op_a;
        mul_start = 1'b1;
      end
      LOAD_B:   mul_data  = op_b;
      HOLD_RES: res_valid = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Directed bench for mul_operand_sequencer with a multiplier stand-in and a
// transaction-level reference model checked every cycle.
module tb_mul_operand_sequencer;

  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid, in_ready, mul_start, mul_done, res_valid, res_ready, busy, err;
  logic [W-1:0] in_a, in_b, mul_data, mul_y, res_data;

  always #5 clk = ~clk;

  mul_operand_sequencer #(.WIDTH(W), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_data(mul_data), .mul_start(mul_start), .mul_done(mul_done), .mul_y(mul_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Multiplier stand-in: latency grows with B (capped), done is a level that
  // stays high until the next start. 'hang' withholds done.
  logic         hang = 1'b0;
  logic [1:0]   m_ph;
  logic [2:0]   m_cnt;
  logic [W-1:0] m_a, m_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= 2'd0; m_cnt <= 3'd0; m_a <= '0; m_b <= '0;
      mul_done <= 1'b0; mul_y <= '0;
    end else if (mul_start) begin
      m_a <= mul_data; mul_done <= 1'b0; m_ph <= 2'd1;
    end else if (m_ph == 2'd1) begin
      m_b   <= mul_data;
      m_cnt <= (mul_data > 16'd4) ? 3'd4 : mul_data[2:0];
      m_ph  <= 2'd2;
    end else if (m_ph == 2'd2 && !hang) begin
      if (m_cnt == 3'd0) begin
        mul_done <= 1'b1; mul_y <= m_a * m_b; m_ph <= 2'd0;
      end else begin
        m_cnt <= m_cnt - 3'd1;
      end
    end
  end

  // Edge events as the DUT sees them at each rising edge.
  logic         ev_push = 1'b0, ev_acc = 1'b0, ev_done = 1'b0, last_start = 1'b0;
  logic [W-1:0] ev_a = '0, ev_b = '0;
  logic [W-1:0] acc_log[$];
  logic [W-1:0] ab_log[$];
  logic [W-1:0] exp_q[$];
  int           start_cnt = 0;

  always @(posedge clk) begin
    ev_push = rst_n && in_valid && in_ready;
    ev_a    = in_a;
    ev_b    = in_b;
    ev_acc  = rst_n && res_valid && res_ready;
    ev_done = mul_done;
    if (ev_acc) acc_log.push_back(res_data);
    if (rst_n && (mul_start || last_start)) ab_log.push_back(mul_data);
    if (rst_n && mul_start) start_cnt++;
    last_start = rst_n && mul_start;
  end

  // Reference model: pending pairs queue plus the phase of the pair in flight.
  typedef struct packed { logic [W-1:0] a; logic [W-1:0] b; } pair_t;
  localparam int P_IDLE = 0, P_A = 1, P_B = 2, P_WAIT = 3, P_HOLD = 4;

  pair_t        pend[$];
  pair_t        cur;
  int           ph = P_IDLE;
  int           waited = 0;
  logic [W-1:0] exp_res = '0;
  logic         exp_err = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend.delete(); ph = P_IDLE; exp_err = 1'b0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_quiet", {mul_start, res_valid, busy, err}, 0);
      chk("rst_mul_data", mul_data, 0);
      chk("rst_res_data", res_data, 0);
    end else begin
      case (ph)
        P_IDLE: if (pend.size() > 0) begin cur = pend.pop_front(); ph = P_A; end
        P_A:    ph = P_B;
        P_B:    begin ph = P_WAIT; waited = 0; end
        P_WAIT: begin
          waited++;
          if (ev_done) begin ph = P_HOLD; exp_res = cur.a * cur.b; end
`ifdef MUL_SEQ_TIMEOUT_EN
          else if (waited == TMO) begin ph = P_HOLD; exp_res = '1; exp_err = 1'b1; end
`endif
        end
        P_HOLD: if (ev_acc) ph = P_IDLE;
        default: ph = P_IDLE;
      endcase
      if (ev_push) pend.push_back({ev_a, ev_b});
      chk("mul_start", mul_start, (ph == P_A));
      chk("mul_data", mul_data, (ph == P_A) ? cur.a : (ph == P_B) ? cur.b : 16'd0);
      chk("res_valid", res_valid, (ph == P_HOLD));
      if (ph == P_HOLD) chk("res_data", res_data, exp_res);
      chk("in_ready", in_ready, (pend.size() < DEPTH));
      chk("busy", busy, (ph != P_IDLE) || (pend.size() > 0));
      chk("err", err, exp_err);
    end
  end

  function automatic logic [31:0] qat(input logic [W-1:0] q[$], input int i);
    if (i < q.size()) return 32'(q[i]);
    return 32'hDEAD_BEEF;
  endfunction

  task automatic check_results(input string name);
    chk({name, "_count"}, acc_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_res%0d", name, i), qat(acc_log, i), 32'(exp_q[i]));
    acc_log.delete();
    exp_q.delete();
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    chk("send_accepted", ok, 1);
  endtask

  task automatic wait_idle(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk); ok = !busy && !res_valid;
    end
    chk(name, ok, 1);
    @(posedge clk); #2;
  endtask

  task automatic wait_res_valid(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk); ok = res_valid;
    end
    chk(name, ok, 1);
    @(posedge clk); #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int n0;
    in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_err", err, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Single pair 17 x 5
    res_ready = 1'b1; acc_log.delete(); ab_log.delete(); start_cnt = 0;
    send(16'd17, 16'd5);
    wait_idle("t1_idle");
    chk("t1_start_cycles", start_cnt, 1);
    chk("t1_bus_a", qat(ab_log, 0), 17);
    chk("t1_bus_b", qat(ab_log, 1), 5);
    exp_q.push_back(16'd85);
    check_results("t1");

    // FIFO fill with result held, overflow attempt ignored
    res_ready = 1'b0;
    send(16'd3, 16'd4); send(16'd2, 16'd2); send(16'd7, 16'd1);
    send(16'd9, 16'd0); send(16'd1, 16'd1);
    @(negedge clk);
    chk("t2_full", in_ready, 0);
    @(posedge clk); #2;
    in_valid = 1'b1; in_a = 16'd99; in_b = 16'd99;
    repeat (4) @(posedge clk);
    #2 in_valid = 1'b0;
    res_ready = 1'b1;
    wait_idle("t2_idle");
    exp_q.push_back(16'd12); exp_q.push_back(16'd4); exp_q.push_back(16'd7);
    exp_q.push_back(16'd0);  exp_q.push_back(16'd1);
    check_results("t2");

    // Backpressure on 6 x 3
    res_ready = 1'b0;
    send(16'd6, 16'd3); send(16'd2, 16'd3);
    wait_res_valid("t3_valid");
    n0 = start_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", res_valid, 1);
      chk("t3_hold_data", res_data, 18);
    end
    chk("t3_no_new_load", start_cnt - n0, 0);
    @(posedge clk); #2;
    res_ready = 1'b1;
    wait_idle("t3_idle");
    exp_q.push_back(16'd18); exp_q.push_back(16'd6);
    check_results("t3");

    // Push on the same edge as the IDLE->LOAD_A pop, two pairs queued
    res_ready = 1'b0;
    send(16'd1, 16'd2); send(16'd3, 16'd4); send(16'd5, 16'd6);
    wait_res_valid("t4_valid");
    res_ready = 1'b1;
    @(posedge clk); #2;
    res_ready = 1'b0; in_valid = 1'b1; in_a = 16'd7; in_b = 16'd8;
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t4_ready_after", in_ready, 1);
    chk("t4_loading", mul_start, 1);
    @(posedge clk); #2;
    send(16'd9, 16'd1); send(16'd2, 16'd5);
    @(negedge clk);
    chk("t4_full", in_ready, 0);
    @(posedge clk); #2;
    res_ready = 1'b1;
    wait_idle("t4_idle");
    exp_q.push_back(16'd2);  exp_q.push_back(16'd12); exp_q.push_back(16'd30);
    exp_q.push_back(16'd56); exp_q.push_back(16'd9);  exp_q.push_back(16'd10);
    check_results("t4");

    // Asynchronous reset during WAIT_DONE with two pairs queued
    hang = 1'b1; res_ready = 1'b1;
    send(16'd4, 16'd4); send(16'd5, 16'd5); send(16'd6, 16'd6);
    repeat (2) @(posedge clk);
    #2;
    chk("t5_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_in_ready", in_ready, 1);
    chk("t5_busy", busy, 0);
    chk("t5_mul_start", mul_start, 0);
    chk("t5_res_valid", res_valid, 0);
    chk("t5_res_data", res_data, 0);
    hang = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    send(16'd10, 16'd10);
    wait_idle("t5_idle");
    exp_q.push_back(16'd100);
    check_results("t5");

`ifdef MUL_SEQ_TIMEOUT_EN
    // Watchdog expiry, then err stays set through a good transaction
    hang = 1'b1; res_ready = 1'b0;
    send(16'd3, 16'd3);
    wait_res_valid("t6_valid");
    chk("t6_err", err, 1);
    chk("t6_res_data", res_data, 16'hFFFF);
    hang = 1'b0; res_ready = 1'b1;
    wait_idle("t6_idle");
    send(16'd2, 16'd3);
    wait_idle("t6_idle2");
    chk("t6_err_sticky", err, 1);
    exp_q.push_back(16'hFFFF); exp_q.push_back(16'd6);
    check_results("t6");
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
